// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32 core: FSM states, opcodes and datapath select codes.
// CTRL_LUI_EN (when defined) makes lui a legal instruction with a U-type immediate select.
package riscv_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  typedef enum logic [3:0] {
    FETCH    = S_FETCH,
    DECODE   = S_DECODE,
    MEMADR   = S_MEMADR,
    MEMREAD  = S_MEMREAD,
    MEMWB    = S_MEMWB,
    MEMWRITE = S_MEMWRITE,
    EXECR    = S_EXECR,
    EXECI    = S_EXECI,
    ALUWB    = S_ALUWB,
    BRANCH   = S_BRANCH,
    JAL      = S_JAL,
    LUI      = S_LUI,
    TRAP     = S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // What the ALU decoder should do in the current state.
  typedef enum logic [1:0] {
    ACLS_ADD   = 2'b00,
    ACLS_SUB   = 2'b01,
    ACLS_RTYPE = 2'b10,
    ACLS_ITYPE = 2'b11
  } aluclass_t;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    logic [2:0] sel;
    sel = IMM_I;
    case (op)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_JAL:    sel = IMM_J;
`ifdef CTRL_LUI_EN
      OP_LUI:    sel = IMM_U;
`endif
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder: maps the state's ALU class plus funct3/funct7b5 to an alucontrol code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluclass_t  aclass,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aclass)
      ACLS_SUB: alucontrol = ALU_SUB;
      ACLS_RTYPE, ACLS_ITYPE: begin
        case (funct3)
          // funct7b5 selects sub only for register-register ops; addi has no sub form
          3'b000:  alucontrol = (aclass == ACLS_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b100:  alucontrol = ALU_XOR;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32 core; outputs are decoded combinationally from the state.
// Optional CTRL_LUI_EN adds the LUI state; without it lui traps as an illegal opcode.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit TRAP_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       regwrite,
  output logic       illegal
);

  state_t    state_reg, state_next;
  aluclass_t aclass;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECR;
          OP_ITYPE:          state_next = EXECI;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
`ifdef CTRL_LUI_EN
          OP_LUI:            state_next = LUI;
`endif
          default:           state_next = TRAP;
        endcase
      end
      MEMADR:   state_next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: if (mem_ready) state_next = FETCH;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      JAL:      state_next = ALUWB;
      LUI:      state_next = ALUWB;
      TRAP:     if (!TRAP_STICKY) state_next = FETCH;
      default:  state_next = FETCH;
    endcase
  end

  always_comb begin
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    resultsrc = RES_ALUOUT;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RD2;
    regwrite  = 1'b0;
    illegal   = 1'b0;
    aclass    = ACLS_ADD;
    immsrc    = imm_sel(op);
    case (state_reg)
      FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
      end
      // branch target is precomputed here while the register file is read
      DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
      end
      MEMADR: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
      end
      MEMREAD:  adrsrc = 1'b1;
      MEMWB: begin
        resultsrc = RES_DATA;
        regwrite  = 1'b1;
      end
      MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      EXECR: begin
        alusrca = SRCA_RD1;
        aclass  = ACLS_RTYPE;
      end
      EXECI: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        aclass  = ACLS_ITYPE;
      end
      ALUWB:    regwrite = 1'b1;
      BRANCH: begin
        alusrca = SRCA_RD1;
        aclass  = ACLS_SUB;
        case (funct3)
          3'b000:  pcwrite = zero;
          3'b001:  pcwrite = ~zero;
          default: pcwrite = 1'b0;
        endcase
      end
      JAL: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_FOUR;
        pcwrite = 1'b1;
      end
      LUI: begin
        alusrca = SRCA_ZERO;
        alusrcb = SRCB_IMM;
      end
      TRAP:     illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .aclass     (aclass),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction expected cycle sequences are built from the control rules and compared every cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset, funct7b5, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb;
  logic [2:0] immsrc, alucontrol;
  logic [17:0] outs;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        mr;
    logic        z;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [17:0] exp;
  } step_t;

  step_t q[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcwrite    (pcwrite),
    .adrsrc     (adrsrc),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .immsrc     (immsrc),
    .alucontrol (alucontrol),
    .regwrite   (regwrite),
    .illegal    (illegal)
  );

  assign outs = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
                 immsrc, alucontrol, regwrite, illegal};

  function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] imm,
                                     input logic [2:0] ac, input logic rw, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, ac, rw, ill};
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    if (o == 7'b0100011) return 3'b001;
    if (o == 7'b1100011) return 3'b010;
    if (o == 7'b1101111) return 3'b011;
`ifdef CTRL_LUI_EN
    if (o == 7'b0110111) return 3'b100;
`endif
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rst, input logic mr, input logic z, input logic [6:0] o,
                      input logic [2:0] f3, input logic f7, input logic [17:0] e);
    step_t s;
    s.rst = rst; s.mr = mr; s.z = z; s.op = o; s.f3 = f3; s.f7 = f7; s.exp = e;
    q.push_back(s);
  endtask

  // One instruction from FETCH back to FETCH; an illegal one traps for trapn cycles then is reset.
  task automatic build_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int wf, input int wm, input int trapn);
    logic [2:0] imm;
    logic       taken;
    imm = exp_imm(o);
    for (int i = 0; i < wf; i++) push(0, 0, rbit(), o, f3, f7, mk(0,0,0,0,2'b10,2'b00,2'b10,imm,3'b000,0,0));
    push(0, 1, rbit(), o, f3, f7, mk(1,0,0,1,2'b10,2'b00,2'b10,imm,3'b000,0,0));
    push(0, rbit(), rbit(), o, f3, f7, mk(0,0,0,0,2'b00,2'b01,2'b01,imm,3'b000,0,0));
    if (o == 7'b0000011) begin
      push(0, rbit(), rbit(), o, f3, f7, mk(0,0,0,0,2'b00,2'b10,2'b01,imm,3'b000,0,0));
      for (int i = 0; i < wm; i++) push(0, 0, rbit(), o, f3, f7, mk(0,1,0,0,2'b00,2'b00,2'b00,imm,3'b000,0,0));
      push(0, 1, rbit(), o, f3, f7, mk(0,1,0,0,2'b00,2'b00,2'b00,imm,3'b000,0,0));
      push(0, rbit(), rbit(), o, f3, f7, mk(0,0,0,0,2'b01,2'b00,2'b00,imm,3'b000,1,0));
    end else if (o == 7'b0100011) begin
      push(0, rbit(), rbit(), o, f3, f7, mk(0,0,0,0,2'b00,2'b10,2'b01,imm,3'b000,0,0));
      for (int i = 0; i < wm; i++) push(0, 0, rbit(), o, f3, f7, mk(0,1,1,0,2'b00,2'b00,2'b00,imm,3'b000,0,0));
      push(0, 1, rbit(), o, f3, f7, mk(0,1,1,0,2'b00,2'b00,2'b00,imm,3'b000,0,0));
    end else if (o == 7'b0110011 || o == 7'b0010011) begin
      push(0, rbit(), rbit(), o, f3, f7, mk(0,0,0,0,2'b00,2'b10,(o == 7'b0110011) ? 2'b00 : 2'b01,
                                            imm, exp_alu(f3, f7, o == 7'b0110011), 0, 0));
      push(0, rbit(), rbit(), o, f3, f7, mk(0,0,0,0,2'b00,2'b00,2'b00,imm,3'b000,1,0));
    end else if (o == 7'b1100011) begin
      taken = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? !z : 1'b0);
      push(0, rbit(), z, o, f3, f7, mk(taken,0,0,0,2'b00,2'b10,2'b00,imm,3'b001,0,0));
    end else if (o == 7'b1101111) begin
      push(0, rbit(), rbit(), o, f3, f7, mk(1,0,0,0,2'b00,2'b01,2'b10,imm,3'b000,0,0));
      push(0, rbit(), rbit(), o, f3, f7, mk(0,0,0,0,2'b00,2'b00,2'b00,imm,3'b000,1,0));
`ifdef CTRL_LUI_EN
    end else if (o == 7'b0110111) begin
      push(0, rbit(), rbit(), o, f3, f7, mk(0,0,0,0,2'b00,2'b11,2'b01,imm,3'b000,0,0));
      push(0, rbit(), rbit(), o, f3, f7, mk(0,0,0,0,2'b00,2'b00,2'b00,imm,3'b000,1,0));
`endif
    end else begin
      for (int i = 0; i < trapn; i++) push(0, rbit(), rbit(), o, f3, f7, mk(0,0,0,0,2'b00,2'b00,2'b00,imm,3'b000,0,1));
      push(1, rbit(), rbit(), o, f3, f7, mk(0,0,0,0,2'b00,2'b00,2'b00,imm,3'b000,0,0));
    end
  endtask

  task automatic apply(input step_t s);
    @(negedge clk);
    reset = s.rst; mem_ready = s.mr; zero = s.z; op = s.op; funct3 = s.f3; funct7b5 = s.f7;
    #1;
  endtask

  task automatic test_reset;
    step_t s;
    s.rst = 1; s.mr = 1; s.z = 0; s.op = 7'b0110011; s.f3 = 3'b000; s.f7 = 0; s.exp = '0;
    apply(s);
    apply(s);
    total++;
    if (outs !== mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0,0)) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h", outs, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0,0));
    end
    $display("reset checked outs=%h", outs);
  endtask

  task automatic test_add;
    step_t s;
    int n = 0;
    q.delete();
    build_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); total++; n++;
      if (outs !== s.exp) begin bad++; $display("FAIL add cycle%0d got=%h exp=%h", n, outs, s.exp); end
    end
    $display("add x3,x1,x2 checked over %0d cycles", n);
  endtask

  task automatic test_lw_wait;
    step_t s;
    int n = 0;
    q.delete();
    build_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1, 3, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); total++; n++;
      if (outs !== s.exp) begin bad++; $display("FAIL lw_wait cycle%0d got=%h exp=%h", n, outs, s.exp); end
    end
    $display("lw with 3 wait cycles checked over %0d cycles", n);
  endtask

  task automatic test_sw;
    step_t s;
    int n = 0;
    q.delete();
    build_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 2, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); total++; n++;
      if (outs !== s.exp) begin bad++; $display("FAIL sw cycle%0d got=%h exp=%h", n, outs, s.exp); end
    end
    $display("sw with 2 wait cycles checked over %0d cycles", n);
  endtask

  task automatic test_branch;
    step_t s;
    int n = 0;
    q.delete();
    build_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 0);
    build_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, 0);
    build_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, 0);
    build_instr(7'b1100011, 3'b100, 1'b0, 1'b1, 0, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); total++; n++;
      if (outs !== s.exp) begin bad++; $display("FAIL branch cycle%0d got=%h exp=%h", n, outs, s.exp); end
    end
    $display("beq/bne/blt checked over %0d cycles", n);
  endtask

  task automatic test_trap;
    step_t s;
    int n = 0;
    q.delete();
    build_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 10);
    build_instr(7'b0010011, 3'b100, 1'b1, 1'b0, 0, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); total++; n++;
      if (outs !== s.exp) begin bad++; $display("FAIL trap cycle%0d got=%h exp=%h", n, outs, s.exp); end
    end
    $display("illegal opcode trap then reset checked over %0d cycles", n);
  endtask

  task automatic test_lui;
    step_t s;
    int n = 0;
    q.delete();
    build_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0, 3);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); total++; n++;
      if (outs !== s.exp) begin bad++; $display("FAIL lui cycle%0d got=%h exp=%h", n, outs, s.exp); end
    end
    $display("lui checked over %0d cycles", n);
  endtask

  task automatic test_reset_midwait;
    step_t s;
    int n = 0;
    q.delete();
    push(0, 1, 0, 7'b0000011, 3'b010, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,3'b000,0,0));
    push(0, 0, 0, 7'b0000011, 3'b010, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0,0));
    push(0, 0, 0, 7'b0000011, 3'b010, 0, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0,0));
    push(0, 0, 0, 7'b0000011, 3'b010, 0, mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0));
    push(1, 0, 0, 7'b0000011, 3'b010, 0, mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0));
    build_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); total++; n++;
      if (outs !== s.exp) begin bad++; $display("FAIL reset_midwait cycle%0d got=%h exp=%h", n, outs, s.exp); end
    end
    $display("reset during MEMREAD wait checked over %0d cycles", n);
  endtask

  task automatic test_random;
    step_t s;
    int n = 0;
    logic [6:0] ops [0:10];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
            7'b0110111, 7'b1111111, 7'b0000000, 7'b1110011, 7'b0010111};
    q.delete();
    for (int k = 0; k < 60; k++) begin
      build_instr(ops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)), rbit(), rbit(),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4));
    end
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); total++; n++;
      if (outs !== s.exp) begin
        bad++;
        $display("FAIL random cycle%0d op=%b f3=%b got=%h exp=%h", n, s.op, s.f3, outs, s.exp);
      end
    end
    $display("random program of 60 instructions checked over %0d cycles", n);
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_sw();
    test_branch();
    test_trap();
    test_lui();
    test_reset_midwait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
